// File: rtl/jelly2_wb2axi4l_pkg.sv
// Shared types and constants for the Wishbone to AXI4-Lite bridge.
package jelly2_wb2axi4l_pkg;

  // Bridge sequencer states; one WB cycle walks IDLE -> (WRITE,WRESP | READ,RRESP) -> ACK.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    READ  = 3'd3,
    RRESP = 3'd4,
    ACK   = 3'd5
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // True while an AXI transaction is in flight (the states that may stall on the slave).
  function automatic logic is_busy(input state_t st);
    return (st == WRITE) || (st == WRESP) || (st == READ) || (st == RRESP);
  endfunction

endpackage

// File: rtl/jelly2_wishbone_to_axi4l.sv
// Wishbone slave to AXI4-Lite master bridge, one transaction at a time.
// Optional macro JELLY2_WB2AXI4L_TIMEOUT_EN adds parameter TIMEOUT_CYCLES and
// abandons a transaction (error ack, all-ones read data) if the slave stalls.
module jelly2_wishbone_to_axi4l
  import jelly2_wb2axi4l_pkg::*;
  #(
    parameter int         WB_DAT_SIZE      = 2,
    parameter int         WB_ADR_WIDTH     = 30,
    parameter int         WB_DAT_WIDTH     = (8 << WB_DAT_SIZE),
    parameter int         WB_SEL_WIDTH     = (1 << WB_DAT_SIZE),
    parameter int         AXI4L_ADDR_WIDTH = (WB_ADR_WIDTH + WB_DAT_SIZE),
    parameter logic [2:0] AXI4L_PROT       = 3'b000
`ifdef JELLY2_WB2AXI4L_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYCLES   = 1023
`endif
  )
  (
    input  logic                        reset,
    input  logic                        clk,

    input  logic [WB_ADR_WIDTH-1:0]     s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0]     s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0]     s_wb_dat_o,
    input  logic [WB_SEL_WIDTH-1:0]     s_wb_sel_i,
    input  logic                        s_wb_we_i,
    input  logic                        s_wb_stb_i,
    output logic                        s_wb_ack_o,
    output logic                        resp_err,

    output logic [AXI4L_ADDR_WIDTH-1:0] m_axi4l_awaddr,
    output logic [2:0]                  m_axi4l_awprot,
    output logic                        m_axi4l_awvalid,
    input  logic                        m_axi4l_awready,
    output logic [WB_DAT_WIDTH-1:0]     m_axi4l_wdata,
    output logic [WB_SEL_WIDTH-1:0]     m_axi4l_wstrb,
    output logic                        m_axi4l_wvalid,
    input  logic                        m_axi4l_wready,
    input  logic [1:0]                  m_axi4l_bresp,
    input  logic                        m_axi4l_bvalid,
    output logic                        m_axi4l_bready,
    output logic [AXI4L_ADDR_WIDTH-1:0] m_axi4l_araddr,
    output logic [2:0]                  m_axi4l_arprot,
    output logic                        m_axi4l_arvalid,
    input  logic                        m_axi4l_arready,
    input  logic [WB_DAT_WIDTH-1:0]     m_axi4l_rdata,
    input  logic [1:0]                  m_axi4l_rresp,
    input  logic                        m_axi4l_rvalid,
    output logic                        m_axi4l_rready
  );

  state_t                      state;
  state_t                      state_next;

  logic [AXI4L_ADDR_WIDTH-1:0] addr;
  logic [WB_DAT_WIDTH-1:0]     wdat;
  logic [WB_SEL_WIDTH-1:0]     wsel;
  logic [WB_DAT_WIDTH-1:0]     rdat;
  logic                        aw_done;
  logic                        w_done;
  logic                        err;

  logic                        aw_fire;
  logic                        w_fire;
  logic                        aw_ok;
  logic                        w_ok;
  logic                        ar_fire;
  logic                        b_take;
  logic                        r_take;
  logic                        timeout;

  // AXI/WB outputs decoded from state so a reset drops every valid immediately.
  always_comb begin
    m_axi4l_awaddr  = addr;
    m_axi4l_awprot  = AXI4L_PROT;
    m_axi4l_awvalid = (state == WRITE) && !aw_done;
    m_axi4l_wdata   = wdat;
    m_axi4l_wstrb   = wsel;
    m_axi4l_wvalid  = (state == WRITE) && !w_done;
    m_axi4l_bready  = (state == WRITE) || (state == WRESP);
    m_axi4l_araddr  = addr;
    m_axi4l_arprot  = AXI4L_PROT;
    m_axi4l_arvalid = (state == READ);
    m_axi4l_rready  = (state == RRESP);
    s_wb_ack_o      = (state == ACK);
    resp_err        = (state == ACK) && err;
    s_wb_dat_o      = rdat;
  end

  // Handshake qualifiers; aw_ok/w_ok include a handshake landing on this edge.
  always_comb begin
    aw_fire = m_axi4l_awvalid && m_axi4l_awready;
    w_fire  = m_axi4l_wvalid  && m_axi4l_wready;
    aw_ok   = aw_done || aw_fire;
    w_ok    = w_done  || w_fire;
    ar_fire = m_axi4l_arvalid && m_axi4l_arready;
    // A B response is only accepted once both address and data have been handed over.
    b_take  = m_axi4l_bvalid && (((state == WRITE) && aw_ok && w_ok) || (state == WRESP));
    r_take  = m_axi4l_rvalid && (state == RRESP);
  end

`ifdef JELLY2_WB2AXI4L_TIMEOUT_EN
  logic [31:0] to_cnt;

  // Count cycles spent waiting on the AXI side; cleared outside the busy states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (!is_busy(state)) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 32'd1;
    end
  end

  // A response arriving on the deadline cycle wins over the timeout.
  always_comb begin
    timeout = is_busy(state) && (to_cnt >= 32'(TIMEOUT_CYCLES - 1)) && !b_take && !r_take;
  end
`else
  always_comb begin
    timeout = 1'b0;
  end
`endif

  // Next-state sequencing for one WB cycle mapped onto one AXI transaction.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (s_wb_stb_i) begin
          state_next = s_wb_we_i ? WRITE : READ;
        end
      end
      WRITE: begin
        if (b_take) begin
          state_next = ACK;
        end else if (aw_ok && w_ok) begin
          state_next = WRESP;
        end
      end
      WRESP: begin
        if (b_take) begin
          state_next = ACK;
        end
      end
      READ: begin
        if (ar_fire) begin
          state_next = RRESP;
        end
      end
      RRESP: begin
        if (r_take) begin
          state_next = ACK;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (timeout) begin
      state_next = ACK;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request latch, per-channel handshake tracking and response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr    <= '0;
      wdat    <= '0;
      wsel    <= '0;
      rdat    <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err     <= 1'b0;
    end else begin
      if ((state == IDLE) && s_wb_stb_i) begin
        addr    <= AXI4L_ADDR_WIDTH'(s_wb_adr_i) << WB_DAT_SIZE;
        wdat    <= s_wb_dat_i;
        wsel    <= s_wb_sel_i;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        err     <= 1'b0;
      end
      if (state == WRITE) begin
        aw_done <= aw_ok;
        w_done  <= w_ok;
      end
      if (b_take) begin
        err <= (m_axi4l_bresp != AXI_RESP_OKAY);
      end
      if (r_take) begin
        rdat <= m_axi4l_rdata;
        err  <= (m_axi4l_rresp != AXI_RESP_OKAY);
      end
      if (timeout) begin
        err <= 1'b1;
        if ((state == READ) || (state == RRESP)) begin
          rdat <= '1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jelly2_wishbone_to_axi4l.sv
// Scoreboard bench for jelly2_wishbone_to_axi4l with a negedge-driven AXI4-Lite slave model.
`timescale 1ns/1ps
module tb_jelly2_wishbone_to_axi4l;

  localparam int DW    = 32;
  localparam int SW    = 4;
  localparam int AW    = 32;
  localparam int LIMIT = 200;
`ifdef JELLY2_WB2AXI4L_TIMEOUT_EN
  localparam int TO_CYCLES = 8;
`endif

  logic          reset, clk;
  logic [29:0]   s_wb_adr_i;
  logic [DW-1:0] s_wb_dat_i, s_wb_dat_o;
  logic [SW-1:0] s_wb_sel_i;
  logic          s_wb_we_i, s_wb_stb_i, s_wb_ack_o, resp_err;
  logic [AW-1:0] m_axi4l_awaddr, m_axi4l_araddr;
  logic [2:0]    m_axi4l_awprot, m_axi4l_arprot;
  logic          m_axi4l_awvalid, m_axi4l_awready, m_axi4l_wvalid, m_axi4l_wready;
  logic [DW-1:0] m_axi4l_wdata, m_axi4l_rdata;
  logic [SW-1:0] m_axi4l_wstrb;
  logic [1:0]    m_axi4l_bresp, m_axi4l_rresp;
  logic          m_axi4l_bvalid, m_axi4l_bready, m_axi4l_arvalid, m_axi4l_arready;
  logic          m_axi4l_rvalid, m_axi4l_rready;

  jelly2_wishbone_to_axi4l #(
    .WB_DAT_SIZE      (2),
    .WB_ADR_WIDTH     (30),
    .WB_DAT_WIDTH     (DW),
    .WB_SEL_WIDTH     (SW),
    .AXI4L_ADDR_WIDTH (AW),
    .AXI4L_PROT       (3'b000)
`ifdef JELLY2_WB2AXI4L_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES   (TO_CYCLES)
`endif
  ) dut (
    .reset(reset), .clk(clk),
    .s_wb_adr_i(s_wb_adr_i), .s_wb_dat_i(s_wb_dat_i), .s_wb_dat_o(s_wb_dat_o),
    .s_wb_sel_i(s_wb_sel_i), .s_wb_we_i(s_wb_we_i), .s_wb_stb_i(s_wb_stb_i),
    .s_wb_ack_o(s_wb_ack_o), .resp_err(resp_err),
    .m_axi4l_awaddr(m_axi4l_awaddr), .m_axi4l_awprot(m_axi4l_awprot),
    .m_axi4l_awvalid(m_axi4l_awvalid), .m_axi4l_awready(m_axi4l_awready),
    .m_axi4l_wdata(m_axi4l_wdata), .m_axi4l_wstrb(m_axi4l_wstrb),
    .m_axi4l_wvalid(m_axi4l_wvalid), .m_axi4l_wready(m_axi4l_wready),
    .m_axi4l_bresp(m_axi4l_bresp), .m_axi4l_bvalid(m_axi4l_bvalid), .m_axi4l_bready(m_axi4l_bready),
    .m_axi4l_araddr(m_axi4l_araddr), .m_axi4l_arprot(m_axi4l_arprot),
    .m_axi4l_arvalid(m_axi4l_arvalid), .m_axi4l_arready(m_axi4l_arready),
    .m_axi4l_rdata(m_axi4l_rdata), .m_axi4l_rresp(m_axi4l_rresp),
    .m_axi4l_rvalid(m_axi4l_rvalid), .m_axi4l_rready(m_axi4l_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          err;
  } ack_exp_t;

  logic [AW-1:0]    exp_aw_q[$];
  logic [DW+SW-1:0] exp_w_q[$];
  logic [AW-1:0]    exp_ar_q[$];
  ack_exp_t         exp_ack_q[$];

  int checks = 0;
  int errors = 0;

  // Slave model configuration and statistics.
  int            aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]    bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [DW-1:0] rdata_cfg = '0;
  bit            silent = 1'b0;
  int            aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
  bit            aw_dropped_first = 1'b0;
  logic [DW-1:0] last_rd = '0;

  // AXI4-Lite slave: decides readies/valids at each negedge for the following posedge.
  initial begin : slave
    bit aw_got, w_got, ar_got, b_pend, r_pend;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [AW-1:0]    ea;
    logic [DW+SW-1:0] ew;
    aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    m_axi4l_awready = 0; m_axi4l_wready = 0; m_axi4l_bvalid = 0; m_axi4l_bresp = 0;
    m_axi4l_arready = 0; m_axi4l_rvalid = 0; m_axi4l_rresp = 0; m_axi4l_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        m_axi4l_awready = 0; m_axi4l_wready = 0; m_axi4l_bvalid = 0;
        m_axi4l_arready = 0; m_axi4l_rvalid = 0;
        continue;
      end
      // B channel
      if (b_pend) begin
        m_axi4l_bvalid = 0; b_pend = 0; aw_got = 0; w_got = 0; b_hs++;
      end else if (m_axi4l_bvalid) begin
        if (m_axi4l_bready) b_pend = 1;
      end else if (aw_got && w_got) begin
        if (b_cnt >= b_delay) begin
          m_axi4l_bvalid = 1; m_axi4l_bresp = bresp_cfg; b_cnt = 0;
          if (m_axi4l_bready) b_pend = 1;
        end else b_cnt++;
      end
      // R channel
      if (r_pend) begin
        m_axi4l_rvalid = 0; r_pend = 0; ar_got = 0; r_hs++;
      end else if (m_axi4l_rvalid) begin
        if (m_axi4l_rready) r_pend = 1;
      end else if (ar_got && !silent) begin
        if (r_cnt >= r_delay) begin
          m_axi4l_rvalid = 1; m_axi4l_rdata = rdata_cfg; m_axi4l_rresp = rresp_cfg; r_cnt = 0;
          if (m_axi4l_rready) r_pend = 1;
        end else r_cnt++;
      end
      if (!m_axi4l_awvalid && m_axi4l_wvalid) aw_dropped_first = 1;
      // AW channel
      m_axi4l_awready = 0;
      if (m_axi4l_awvalid && !aw_got) begin
        if (aw_cnt >= aw_delay) begin
          m_axi4l_awready = 1; aw_got = 1; aw_cnt = 0; aw_hs++;
          checks++;
          if (exp_aw_q.size() == 0) begin
            errors++; $display("FAIL aw_unexpected: awaddr=%h with no expected AW", m_axi4l_awaddr);
          end else begin
            ea = exp_aw_q.pop_front();
            if (m_axi4l_awaddr !== ea) begin
              errors++; $display("FAIL awaddr: got %h expected %h", m_axi4l_awaddr, ea);
            end
          end
        end else aw_cnt++;
      end
      // W channel
      m_axi4l_wready = 0;
      if (m_axi4l_wvalid && !w_got) begin
        if (w_cnt >= w_delay) begin
          m_axi4l_wready = 1; w_got = 1; w_cnt = 0; w_hs++;
          checks++;
          if (exp_w_q.size() == 0) begin
            errors++; $display("FAIL w_unexpected: wdata=%h with no expected W", m_axi4l_wdata);
          end else begin
            ew = exp_w_q.pop_front();
            if ({m_axi4l_wdata, m_axi4l_wstrb} !== ew) begin
              errors++; $display("FAIL wdata_wstrb: got %h/%h expected %h/%h",
                                 m_axi4l_wdata, m_axi4l_wstrb, ew[DW+SW-1:SW], ew[SW-1:0]);
            end
          end
        end else w_cnt++;
      end
      // AR channel
      m_axi4l_arready = 0;
      if (m_axi4l_arvalid && !ar_got) begin
        if (ar_cnt >= ar_delay) begin
          m_axi4l_arready = 1; ar_got = 1; ar_cnt = 0; ar_hs++;
          checks++;
          if (exp_ar_q.size() == 0) begin
            errors++; $display("FAIL ar_unexpected: araddr=%h with no expected AR", m_axi4l_araddr);
          end else begin
            ea = exp_ar_q.pop_front();
            if (m_axi4l_araddr !== ea) begin
              errors++; $display("FAIL araddr: got %h expected %h", m_axi4l_araddr, ea);
            end
          end
        end else ar_cnt++;
      end
    end
  end

  // Drives one WB request from a negedge and waits (bounded) for ack.
  task automatic wb_xfer(input logic we, input logic [29:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel, input bit hold,
                         output logic [DW-1:0] rd, output logic err, output int cyc, output bit ok);
    s_wb_we_i = we; s_wb_adr_i = adr; s_wb_dat_i = dat; s_wb_sel_i = sel; s_wb_stb_i = 1'b1;
    ok = 0; cyc = 0; rd = '0; err = 1'b0;
    while (!ok && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (s_wb_ack_o) begin
        ok = 1; rd = s_wb_dat_o; err = resp_err;
      end
    end
    if (!hold) s_wb_stb_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_wb_stb_i = 0; s_wb_we_i = 0; s_wb_adr_i = '0; s_wb_dat_i = '0; s_wb_sel_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_axi4l_awvalid, m_axi4l_wvalid, m_axi4l_bready, m_axi4l_arvalid, m_axi4l_rready,
         s_wb_ack_o, resp_err} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000000",
        {m_axi4l_awvalid, m_axi4l_wvalid, m_axi4l_bready, m_axi4l_arvalid, m_axi4l_rready, s_wb_ack_o, resp_err});
    end
    checks++;
    if ({s_wb_dat_o, m_axi4l_awaddr} !== '0) begin
      errors++; $display("FAIL reset_data: dat_o=%h awaddr=%h expected 0", s_wb_dat_o, m_axi4l_awaddr);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    logic [DW-1:0] rd; logic err; int cyc; bit ok; ack_exp_t e;
    exp_aw_q.push_back(32'h0000_0040);
    exp_w_q.push_back({32'h1234_5678, 4'hF});
    exp_ack_q.push_back('{dat: last_rd, err: 1'b0});
    wb_xfer(1'b1, 30'h10, 32'h1234_5678, 4'hF, 1'b0, rd, err, cyc, ok);
    e = exp_ack_q.pop_front();
    checks++;
    if (!ok) begin errors++; $display("FAIL write_ack: no ack within %0d cycles", LIMIT); end
    checks++;
    if ({rd, err} !== {e.dat, e.err}) begin
      errors++; $display("FAIL write_resp: got dat=%h err=%b expected dat=%h err=%b", rd, err, e.dat, e.err);
    end
    checks++;
    if (cyc !== 3) begin errors++; $display("FAIL write_latency: got %0d expected 3", cyc); end
    checks++;
    if ({m_axi4l_awprot, m_axi4l_arprot} !== 6'b0) begin
      errors++; $display("FAIL prot: got %b expected 000000", {m_axi4l_awprot, m_axi4l_arprot});
    end
    @(negedge clk);
    checks++;
    if (s_wb_ack_o !== 1'b0) begin errors++; $display("FAIL ack_pulse: got %b expected 0", s_wb_ack_o); end
  endtask

  task automatic test_read_wait();
    logic [DW-1:0] rd; logic err; int cyc; bit ok; ack_exp_t e;
    r_delay = 5; rdata_cfg = 32'hCAFE_BABE;
    exp_ar_q.push_back(32'h0000_0080);
    exp_ack_q.push_back('{dat: 32'hCAFE_BABE, err: 1'b0});
    last_rd = 32'hCAFE_BABE;
    wb_xfer(1'b0, 30'h20, '0, 4'hF, 1'b0, rd, err, cyc, ok);
    e = exp_ack_q.pop_front();
    checks++;
    if (!ok) begin errors++; $display("FAIL read_ack: no ack within %0d cycles", LIMIT); end
    checks++;
    if ({rd, err} !== {e.dat, e.err}) begin
      errors++; $display("FAIL read_resp: got dat=%h err=%b expected dat=%h err=%b", rd, err, e.dat, e.err);
    end
    checks++;
    if (cyc !== 3 + 5) begin errors++; $display("FAIL read_latency: got %0d expected 8", cyc); end
    repeat (3) @(negedge clk);
    checks++;
    if (s_wb_dat_o !== 32'hCAFE_BABE) begin
      errors++; $display("FAIL read_hold: got %h expected cafebabe", s_wb_dat_o);
    end
    r_delay = 0;
  endtask

  task automatic test_aw_before_w();
    logic [DW-1:0] rd; logic err; int cyc; bit ok; ack_exp_t e; int aw0, w0;
    aw_delay = 0; w_delay = 3; aw_dropped_first = 0; aw0 = aw_hs; w0 = w_hs;
    exp_aw_q.push_back(32'h0000_0110);
    exp_w_q.push_back({32'hA5A5_5A5A, 4'h3});
    exp_ack_q.push_back('{dat: last_rd, err: 1'b0});
    wb_xfer(1'b1, 30'h44, 32'hA5A5_5A5A, 4'h3, 1'b0, rd, err, cyc, ok);
    e = exp_ack_q.pop_front();
    checks++;
    if (!ok || {rd, err} !== {e.dat, e.err}) begin
      errors++; $display("FAIL split_resp: ok=%b dat=%h err=%b expected dat=%h err=%b", ok, rd, err, e.dat, e.err);
    end
    checks++;
    if (cyc !== 6) begin errors++; $display("FAIL split_latency: got %0d expected 6", cyc); end
    checks++;
    if ({aw_hs - aw0, w_hs - w0} !== {32'd1, 32'd1}) begin
      errors++; $display("FAIL split_hs_count: aw=%0d w=%0d expected 1 1", aw_hs - aw0, w_hs - w0);
    end
    checks++;
    if (aw_dropped_first !== 1'b1) begin
      errors++; $display("FAIL split_order: awvalid-low-wvalid-high seen=%b expected 1", aw_dropped_first);
    end
    w_delay = 0;
  endtask

  task automatic test_slverr();
    logic [DW-1:0] rd; logic err; int cyc; bit ok; ack_exp_t e;
    bresp_cfg = 2'b10;
    exp_aw_q.push_back(32'h0000_0200);
    exp_w_q.push_back({32'h0000_00FF, 4'h1});
    exp_ack_q.push_back('{dat: last_rd, err: 1'b1});
    wb_xfer(1'b1, 30'h80, 32'h0000_00FF, 4'h1, 1'b0, rd, err, cyc, ok);
    e = exp_ack_q.pop_front();
    checks++;
    if (!ok || {rd, err} !== {e.dat, e.err}) begin
      errors++; $display("FAIL slverr_resp: ok=%b dat=%h err=%b expected dat=%h err=%b", ok, rd, err, e.dat, e.err);
    end
    bresp_cfg = 2'b00; rdata_cfg = 32'h0BAD_F00D;
    exp_ar_q.push_back(32'h0000_0204);
    exp_ack_q.push_back('{dat: 32'h0BAD_F00D, err: 1'b0});
    last_rd = 32'h0BAD_F00D;
    wb_xfer(1'b0, 30'h81, '0, 4'hF, 1'b0, rd, err, cyc, ok);
    e = exp_ack_q.pop_front();
    checks++;
    if (!ok || {rd, err} !== {e.dat, e.err}) begin
      errors++; $display("FAIL okay_after_err: ok=%b dat=%h err=%b expected dat=%h err=%b", ok, rd, err, e.dat, e.err);
    end
    // Zero byte enables still go out as a write with an all-zero strobe.
    exp_aw_q.push_back(32'h0000_0300);
    exp_w_q.push_back({32'h5555_AAAA, 4'h0});
    exp_ack_q.push_back('{dat: last_rd, err: 1'b0});
    wb_xfer(1'b1, 30'hC0, 32'h5555_AAAA, 4'h0, 1'b0, rd, err, cyc, ok);
    e = exp_ack_q.pop_front();
    checks++;
    if (!ok || {rd, err} !== {e.dat, e.err}) begin
      errors++; $display("FAIL zero_sel_resp: ok=%b dat=%h err=%b expected dat=%h err=%b", ok, rd, err, e.dat, e.err);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd; logic err; int cyc; bit ok; ack_exp_t e; int aw0, w0, ar0;
    aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs;
    exp_aw_q.push_back(32'h0000_00C0);
    exp_w_q.push_back({32'hDEAD_BEEF, 4'hC});
    exp_ack_q.push_back('{dat: last_rd, err: 1'b0});
    wb_xfer(1'b1, 30'h30, 32'hDEAD_BEEF, 4'hC, 1'b1, rd, err, cyc, ok);
    e = exp_ack_q.pop_front();
    checks++;
    if (!ok || {rd, err} !== {e.dat, e.err}) begin
      errors++; $display("FAIL b2b_first: ok=%b dat=%h err=%b expected dat=%h err=%b", ok, rd, err, e.dat, e.err);
    end
    rdata_cfg = 32'h1357_2468;
    exp_ar_q.push_back(32'h0000_00C4);
    exp_ack_q.push_back('{dat: 32'h1357_2468, err: 1'b0});
    last_rd = 32'h1357_2468;
    wb_xfer(1'b0, 30'h31, '0, 4'hF, 1'b0, rd, err, cyc, ok);
    e = exp_ack_q.pop_front();
    checks++;
    if (!ok || {rd, err} !== {e.dat, e.err}) begin
      errors++; $display("FAIL b2b_second: ok=%b dat=%h err=%b expected dat=%h err=%b", ok, rd, err, e.dat, e.err);
    end
    checks++;
    if (cyc !== 4) begin errors++; $display("FAIL b2b_latency: got %0d expected 4", cyc); end
    checks++;
    if ({aw_hs - aw0, w_hs - w0, ar_hs - ar0} !== {32'd1, 32'd1, 32'd1}) begin
      errors++; $display("FAIL b2b_hs_count: aw=%0d w=%0d ar=%0d expected 1 1 1", aw_hs - aw0, w_hs - w0, ar_hs - ar0);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd; logic err; int cyc; bit ok; ack_exp_t e;
    r_delay = 20;
    exp_ar_q.push_back(32'h0000_0400);
    s_wb_we_i = 1'b0; s_wb_adr_i = 30'h100; s_wb_sel_i = 4'hF; s_wb_stb_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_axi4l_rready, m_axi4l_arvalid} !== 2'b10) begin
      errors++; $display("FAIL mid_pre: rready/arvalid=%b expected 10", {m_axi4l_rready, m_axi4l_arvalid});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({m_axi4l_awvalid, m_axi4l_wvalid, m_axi4l_bready, m_axi4l_arvalid, m_axi4l_rready, s_wb_ack_o} !== 6'b0) begin
      errors++; $display("FAIL mid_reset_async: got %b expected 000000",
        {m_axi4l_awvalid, m_axi4l_wvalid, m_axi4l_bready, m_axi4l_arvalid, m_axi4l_rready, s_wb_ack_o});
    end
    s_wb_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_rd = '0;
    r_delay = 0;
    @(negedge clk);
    checks++;
    if (s_wb_dat_o !== '0) begin errors++; $display("FAIL mid_reset_dat: got %h expected 0", s_wb_dat_o); end
    rdata_cfg = 32'h2468_ACE0;
    exp_ar_q.push_back(32'h0000_0014);
    exp_ack_q.push_back('{dat: 32'h2468_ACE0, err: 1'b0});
    last_rd = 32'h2468_ACE0;
    wb_xfer(1'b0, 30'h5, '0, 4'hF, 1'b0, rd, err, cyc, ok);
    e = exp_ack_q.pop_front();
    checks++;
    if (!ok || {rd, err} !== {e.dat, e.err} || cyc !== 3) begin
      errors++; $display("FAIL mid_recover: ok=%b dat=%h err=%b cyc=%0d expected dat=%h err=%b cyc=3",
                         ok, rd, err, cyc, e.dat, e.err);
    end
  endtask

`ifdef JELLY2_WB2AXI4L_TIMEOUT_EN
  task automatic test_timeout();
    logic [DW-1:0] rd; logic err; int cyc; bit ok;
    silent = 1'b1;
    exp_ar_q.push_back(32'h0000_001C);
    wb_xfer(1'b0, 30'h7, '0, 4'hF, 1'b0, rd, err, cyc, ok);
    checks++;
    if (!ok || err !== 1'b1 || rd !== '1) begin
      errors++; $display("FAIL timeout_resp: ok=%b dat=%h err=%b expected ok=1 dat=ffffffff err=1", ok, rd, err);
    end
    checks++;
    if (cyc < TO_CYCLES || cyc > TO_CYCLES + 2) begin
      errors++; $display("FAIL timeout_latency: got %0d expected %0d..%0d", cyc, TO_CYCLES, TO_CYCLES + 2);
    end
    silent = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_write();
    test_read_wait();
    test_aw_before_w();
    test_slverr();
    test_back_to_back();
    test_reset_mid();
`ifdef JELLY2_WB2AXI4L_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    checks++;
    if ({exp_aw_q.size(), exp_w_q.size(), exp_ar_q.size(), exp_ack_q.size()} !== 128'd0) begin
      errors++; $display("FAIL scoreboard_drain: aw=%0d w=%0d ar=%0d ack=%0d expected all 0",
                         exp_aw_q.size(), exp_w_q.size(), exp_ar_q.size(), exp_ack_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
